mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256, meaning data-memory size in 32-bit words (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 2, meaning cycles per memory access (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 aluResultMEM  input  32  byte address for loads/stores; passthrough value for ALU ops.
REQ-006 regReadData2MEM  input  32  store data.
REQ-007 registerMEM  input  5  destination register number.
REQ-008 memReadMEM, memtoRegMEM, memWriteMEM, regWriteMEM  input  1 each  control bits from EX/MEM.
REQ-009 stallMEM  output  1  high while an access is in progress; upstream holds all inputs stable.
REQ-010 memReadDataWB  output  32  registered load data.
REQ-011 aluResultWB  output  32  registered aluResultMEM.
REQ-012 registerWB  output  5  registered registerMEM.
REQ-013 memtoRegWB, regWriteWB  output  1 each  registered control bits.
REQ-014 addrErrorWB  output  1  registered: faulted access this slot.

Function
REQ-015 Access request = memReadMEM or memWriteMEM; word index = aluResultMEM[log2(DEPTH)+1:2]; upper address bits ignored (wrap).
REQ-016 FSM states IDLE, BUSY; counter cnt of width ceil(log2(LATENCY)) minimum 1.
REQ-017 IDLE, no request or LATENCY==1: no stall; MEM/WB registers capture the current slot at the next edge.
REQ-018 IDLE, valid request, LATENCY>1: stallMEM high combinationally, go BUSY with cnt=LATENCY-2 at next edge.
REQ-019 BUSY: stallMEM high while cnt!=0, cnt decrements; at cnt==0 stallMEM low, at next edge the access completes, the slot is captured into MEM/WB, and state returns to IDLE.
REQ-020 Request first present in cycle t: stallMEM high in cycles t..t+LATENCY-2; write commit and load capture on edge ending cycle t+LATENCY-1.
REQ-021 Each edge with stallMEM high loads a bubble into MEM/WB: regWriteWB=0, memtoRegWB=0, addrErrorWB=0, data outputs 0.
REQ-022 Store writes regReadData2MEM to the indexed word exactly once, on the completion edge.
REQ-023 Load captures the indexed word into memReadDataWB on the completion edge; non-load slots set memReadDataWB=0.
REQ-024 Write then read of the same word in consecutive slots returns the newly written data.
REQ-025 Fault = request with aluResultMEM[1:0]!=0, or memReadMEM and memWriteMEM both high.
REQ-026 Fault: no stall, no memory write, memReadDataWB=0, regWriteWB=0, memtoRegWB=0, addrErrorWB=1 for that one slot.
REQ-027 ALU-only slots (no request) pass aluResultMEM, registerMEM, memtoRegMEM, regWriteMEM to WB with one-cycle latency.

Reset
REQ-028 reset asserted: state=IDLE, cnt=0, stallMEM=0, all WB outputs 0, immediately (asynchronous).
REQ-029 reset during BUSY aborts the access; the pending store is not committed.
REQ-030 Memory contents are zero at time zero and are not cleared by reset.

Structure
REQ-031 State encoding, default DEPTH/LATENCY, and the index-width function live in the shared definitions header included by all pipeline stages.
REQ-032 One sub-module, data_mem: single-port synchronous word array, one write enable, registered read.

Verification
REQ-033 LATENCY=2; store 0xDEADBEEF to 0x10 -> stallMEM high 1 cycle, bubble in WB, word 4 = 0xDEADBEEF after completion edge.
REQ-034 Load from 0x10 in the slot right after REQ-033 -> memReadDataWB=0xDEADBEEF, memtoRegWB=1, regWriteWB=1, registerWB as driven.
REQ-035 ALU slot aluResultMEM=0x1234, registerMEM=7, regWriteMEM=1 -> next cycle aluResultWB=0x1234, registerWB=7, regWriteWB=1, stallMEM never high.
REQ-036 Store to 0x13, then load with memRead and memWrite both high -> each gives addrErrorWB=1, regWriteWB=0, no stall, memory unchanged.
REQ-037 LATENCY=4; store 0x55 to 0x20 with reset asserted during the 2nd stall cycle -> outputs 0 at once, state IDLE, word 8 unchanged.
REQ-038 DEPTH=256; store 0xA5 to 0x400 -> word 0 written (wrap); load from 0x0 returns 0xA5.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: MEM stage state encoding, default sizing,
// and the helper functions used to size the word index and the latency counter.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 2;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Single-port word array for the MEM stage: one write enable and a registered read.
// The read register returns zero whenever no read is requested.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Contents are never reset so stored data survives a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
    else           rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory access with stall, alignment
// fault detection, and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluResultMEM,
  input  logic [31:0] regReadData2MEM,
  input  logic [4:0]  registerMEM,
  input  logic        memReadMEM,
  input  logic        memtoRegMEM,
  input  logic        memWriteMEM,
  input  logic        regWriteMEM,
  output logic        stallMEM,
  output logic [31:0] memReadDataWB,
  output logic [31:0] aluResultWB,
  output logic [4:0]  registerWB,
  output logic        memtoRegWB,
  output logic        regWriteWB,
  output logic        addrErrorWB
);

  localparam int IW = idx_width(DEPTH);
  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   aluResultWB_q;
  logic [4:0]    registerWB_q;
  logic          memtoRegWB_q;
  logic          regWriteWB_q;
  logic          addrErrorWB_q;

  logic req, fault, valid;
  logic stall_d, capture_d;
  logic mem_we, mem_re;

  assign req   = memReadMEM | memWriteMEM;
  assign fault = req & ((aluResultMEM[1:0] != 2'b00) | (memReadMEM & memWriteMEM));
  assign valid = req & ~fault;

  // capture_d marks the edge on which the current slot lands in MEM/WB.
  always_comb begin
    stall_d   = 1'b0;
    capture_d = 1'b0;
    if (state_q == IDLE) begin
      if (valid && (LATENCY > 1)) stall_d   = 1'b1;
      else                        capture_d = 1'b1;
    end else begin
      if (cnt_q != '0) stall_d   = 1'b1;
      else             capture_d = 1'b1;
    end
  end

  assign stallMEM = stall_d & ~reset;
  assign mem_we   = capture_d & valid & memWriteMEM & ~reset;
  assign mem_re   = capture_d & valid & memReadMEM & ~reset;

  data_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_data_mem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (aluResultMEM[IW+1:2]),
    .wdata_i (regReadData2MEM),
    .rdata_o (memReadDataWB)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aluResultWB_q <= '0;
      registerWB_q  <= '0;
      memtoRegWB_q  <= 1'b0;
      regWriteWB_q  <= 1'b0;
      addrErrorWB_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (stall_d) begin
          state_q <= BUSY;
          cnt_q   <= CNT_INIT;
        end
      end else begin
        if (cnt_q != '0) cnt_q   <= cnt_q - CW'(1);
        else             state_q <= IDLE;
      end

      if (stall_d) begin
        aluResultWB_q <= '0;
        registerWB_q  <= '0;
        memtoRegWB_q  <= 1'b0;
        regWriteWB_q  <= 1'b0;
        addrErrorWB_q <= 1'b0;
      end else begin
        aluResultWB_q <= aluResultMEM;
        registerWB_q  <= registerMEM;
        memtoRegWB_q  <= memtoRegMEM & ~fault;
        regWriteWB_q  <= regWriteMEM & ~fault;
        addrErrorWB_q <= fault;
      end
    end
  end

  assign aluResultWB = aluResultWB_q;
  assign registerWB  = registerWB_q;
  assign memtoRegWB  = memtoRegWB_q;
  assign regWriteWB  = regWriteWB_q;
  assign addrErrorWB = addrErrorWB_q;

endmodule
